// File: rtl/led_matrix_scanner_if.sv
// Command / frame-load bus between game logic (master) and the LED matrix scanner (slave).
// The index width covers ROWS*COLS LEDs; indices >= ROWS*COLS are legal but map to nothing.
interface led_matrix_scanner_if #(
    parameter int ROWS = 4,
    parameter int COLS = 4
);
    localparam int N  = ROWS * COLS;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [IW-1:0] cmd_idx;
    logic          frame_load;
    logic [N-1:0]  frame_data;

    modport master (
        output cmd_valid, cmd_op, cmd_idx, frame_load, frame_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_idx, frame_load, frame_data,
        output cmd_ready
    );
endinterface

// File: rtl/led_matrix_scanner.sv
// Time-multiplexed ROWSxCOLS LED matrix driver with a double-buffered bitmap,
// per-row blanking gap, tear-free frame-end swap and optional whole-display blink.
module led_matrix_scanner #(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int DWELL          = 1000,
    parameter int BLANK          = 16,
    parameter int BLINK_FRAMES   = 32,
    parameter int COL_ACTIVE_LOW = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   blink_en,
    led_matrix_scanner_if.slave    bus,
    output logic [ROWS-1:0]        row_out,
    output logic [COLS-1:0]        col_out,
    output logic                   frame_start,
    output logic [ROWS*COLS-1:0]   fb_out
);
    localparam int N  = ROWS * COLS;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int SW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [RW-1:0]   LAST_ROW   = RW'(ROWS - 1);
    localparam logic [SW-1:0]   LAST_SLOT  = SW'(DWELL - 1);
    localparam logic [FW-1:0]   LAST_FRAME = FW'(BLINK_FRAMES - 1);
    localparam logic [COLS-1:0] COL_OFF    = {COLS{(COL_ACTIVE_LOW != 0)}};

    logic [N-1:0]  back_reg, back_next;
    logic [N-1:0]  front_reg;
    logic          dirty_reg, dirty_next;
    logic [RW-1:0] row_idx_reg, row_idx_next;
    logic [SW-1:0] slot_cnt_reg, slot_cnt_next;
    logic [FW-1:0] frame_cnt_reg, frame_cnt_next;
    logic          blink_phase_reg, blink_phase_next;
    logic          en_reg;
    logic          blink_en_reg;

    logic [N-1:0]    hit;
    logic            in_range;
    logic            cmd_accept;
    logic            buf_write;
    logic            frame_end;
    logic            swap;
    logic            in_blank;
    logic            drive;
    logic [COLS-1:0] row_bits [ROWS];
    logic [COLS-1:0] col_on;

    // ---------------- command decode ----------------
    assign bus.cmd_ready = rst_n & ~bus.frame_load;
    assign cmd_accept    = bus.cmd_valid & bus.cmd_ready;

    for (genvar gi = 0; gi < N; gi++) begin : g_hit
        assign hit[gi] = (bus.cmd_idx == IW'(gi));
    end
    assign in_range = |hit;

    always_comb begin
        back_next = back_reg;
        buf_write = 1'b0;
        if (bus.frame_load) begin
            back_next = bus.frame_data;
            buf_write = 1'b1;
        end else if (cmd_accept) begin
            case (bus.cmd_op)
                2'b00: begin back_next = back_reg | hit;  buf_write = in_range; end
                2'b01: begin back_next = back_reg & ~hit; buf_write = in_range; end
                2'b10: begin back_next = back_reg ^ hit;  buf_write = in_range; end
                default: begin back_next = '0;            buf_write = 1'b1;     end
            endcase
        end
    end

    // ---------------- scan counters ----------------
    assign frame_end = (row_idx_reg == LAST_ROW) && (slot_cnt_reg == LAST_SLOT);
    // Counters only advance once en has been seen for a full cycle so that
    // the first visible cycle after enabling is row 0, slot 0.
    assign swap = en & en_reg & frame_end & dirty_reg;

    always_comb begin
        row_idx_next     = row_idx_reg;
        slot_cnt_next    = slot_cnt_reg;
        frame_cnt_next   = frame_cnt_reg;
        blink_phase_next = blink_phase_reg;
        if (!en) begin
            row_idx_next     = '0;
            slot_cnt_next    = '0;
            frame_cnt_next   = '0;
            blink_phase_next = 1'b0;
        end else if (en_reg) begin
            if (slot_cnt_reg == LAST_SLOT) begin
                slot_cnt_next = '0;
                if (row_idx_reg == LAST_ROW) begin
                    row_idx_next = '0;
                    if (frame_cnt_reg == LAST_FRAME) begin
                        frame_cnt_next   = '0;
                        blink_phase_next = ~blink_phase_reg;
                    end else begin
                        frame_cnt_next = frame_cnt_reg + 1'b1;
                    end
                end else begin
                    row_idx_next = row_idx_reg + 1'b1;
                end
            end else begin
                slot_cnt_next = slot_cnt_reg + 1'b1;
            end
        end
    end

    // A write landing on the swap edge keeps dirty so it shows next frame.
    always_comb begin
        dirty_next = dirty_reg;
        if (buf_write) begin
            dirty_next = 1'b1;
        end else if (swap) begin
            dirty_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            back_reg        <= '0;
            front_reg       <= '0;
            dirty_reg       <= 1'b0;
            row_idx_reg     <= '0;
            slot_cnt_reg    <= '0;
            frame_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
            en_reg          <= 1'b0;
            blink_en_reg    <= 1'b0;
        end else begin
            back_reg        <= back_next;
            dirty_reg       <= dirty_next;
            row_idx_reg     <= row_idx_next;
            slot_cnt_reg    <= slot_cnt_next;
            frame_cnt_reg   <= frame_cnt_next;
            blink_phase_reg <= blink_phase_next;
            en_reg          <= en;
            blink_en_reg    <= blink_en;
            if (swap) begin
                front_reg <= back_reg;
            end
        end
    end

    // ---------------- output decode (registered state only) ----------------
    if (BLANK == 0) begin : g_no_blank
        assign in_blank = 1'b0;
    end else begin : g_blank
        assign in_blank = (slot_cnt_reg < SW'(BLANK));
    end

    assign drive = en_reg & ~in_blank;

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_rows
        assign row_bits[gi] = front_reg[gi*COLS +: COLS];
        assign row_out[gi]  = drive & (row_idx_reg == RW'(gi));
    end

    assign col_on      = (drive && !(blink_en_reg && blink_phase_reg)) ? row_bits[row_idx_reg] : '0;
    assign col_out     = col_on ^ COL_OFF;
    assign frame_start = en_reg & (row_idx_reg == '0) & (slot_cnt_reg == '0);
    assign fb_out      = front_reg;
endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner: a 4x4 instance for scan/buffer/blink behaviour
// and a 3x3 instance for the non-power-of-two index space.
module tb_led_matrix_scanner;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 4x4 instance
    logic        rst_n, en, blink_en;
    logic [3:0]  row_out, col_out;
    logic        frame_start;
    logic [15:0] fb_out;
    led_matrix_scanner_if #(.ROWS(4), .COLS(4)) bus ();

    led_matrix_scanner #(.ROWS(4), .COLS(4), .DWELL(8), .BLANK(2),
                         .BLINK_FRAMES(2), .COL_ACTIVE_LOW(0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .blink_en(blink_en), .bus(bus),
        .row_out(row_out), .col_out(col_out), .frame_start(frame_start), .fb_out(fb_out)
    );

    // 3x3 instance
    logic        rst_b_n, en_b, blink_en_b;
    logic [2:0]  row_b, col_b;
    logic        fs_b;
    logic [8:0]  fb_b;
    led_matrix_scanner_if #(.ROWS(3), .COLS(3)) bus_b ();

    led_matrix_scanner #(.ROWS(3), .COLS(3), .DWELL(8), .BLANK(2),
                         .BLINK_FRAMES(2), .COL_ACTIVE_LOW(0)) dut_b (
        .clk(clk), .rst_n(rst_b_n), .en(en_b), .blink_en(blink_en_b), .bus(bus_b),
        .row_out(row_b), .col_out(col_b), .frame_start(fs_b), .fb_out(fb_b)
    );

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  idx;
        logic [15:0] exp_fb;
    } vec_t;
    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_fs(input bit b);
        bit got = 1'b0;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            got = b ? fs_b : frame_start;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL wait_fs: got no frame_start within 100 cycles, expected a pulse");
        end
    endtask

    // Called on the frame_start cycle; walks all 32 row/slot positions of the 4x4 frame.
    task automatic check_frame(input logic [15:0] exp, input bit dark);
        logic [3:0] exp_row, exp_col;
        int r, s;
        for (int k = 0; k < 32; k++) begin
            if (k > 0) @(negedge clk);
            r = k / 8;
            s = k % 8;
            exp_row = (s < 2) ? 4'b0 : (4'b1 << r);
            exp_col = (s < 2 || dark) ? 4'b0 : exp[r*4 +: 4];
            chk($sformatf("row_out r%0d s%0d", r, s), 32'(row_out), 32'(exp_row));
            chk($sformatf("col_out r%0d s%0d", r, s), 32'(col_out), 32'(exp_col));
            chk($sformatf("frame_start k%0d", k), 32'(frame_start), 32'(k == 0));
        end
    endtask

    initial begin
        logic [15:0] prev_fb;
        logic [2:0]  exp_row3, exp_col3;
        int r, s;

        vecs[0] = '{2'b00, 4'd6,  16'h0040};
        vecs[1] = '{2'b00, 4'd15, 16'h8040};
        vecs[2] = '{2'b10, 4'd15, 16'h0040};
        vecs[3] = '{2'b10, 4'd15, 16'h8040};
        vecs[4] = '{2'b01, 4'd6,  16'h8000};
        vecs[5] = '{2'b11, 4'd9,  16'h0000};
        vecs[6] = '{2'b00, 4'd0,  16'h0001};
        vecs[7] = '{2'b10, 4'd3,  16'h0009};

        rst_n = 1'b0; en = 1'b0; blink_en = 1'b0;
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'b00; bus.cmd_idx = 4'd5;
        bus.frame_load = 1'b0; bus.frame_data = '0;
        rst_b_n = 1'b0; en_b = 1'b0; blink_en_b = 1'b0;
        bus_b.cmd_valid = 1'b0; bus_b.cmd_op = 2'b00; bus_b.cmd_idx = '0;
        bus_b.frame_load = 1'b0; bus_b.frame_data = '0;

        // reset with a command pending
        repeat (3) begin
            @(negedge clk);
            chk("reset cmd_ready", 32'(bus.cmd_ready), 0);
            chk("reset row_out", 32'(row_out), 0);
            chk("reset col_out", 32'(col_out), 0);
            chk("reset fb_out", 32'(fb_out), 0);
            chk("reset frame_start", 32'(frame_start), 0);
        end
        bus.cmd_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("release cmd_ready", 32'(bus.cmd_ready), 1);
        en = 1'b1;
        wait_fs(0);
        wait_fs(0);
        chk("no cmd during reset", 32'(fb_out), 0);

        // table of single index commands, one per frame
        prev_fb = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            wait_fs(0);
            repeat (3) @(negedge clk);
            bus.cmd_valid = 1'b1; bus.cmd_op = vecs[i].op; bus.cmd_idx = vecs[i].idx;
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            chk($sformatf("vec%0d fb before wrap", i), 32'(fb_out), 32'(prev_fb));
            wait_fs(0);
            chk($sformatf("vec%0d fb after wrap", i), 32'(fb_out), 32'(vecs[i].exp_fb));
            $display("vec %0d op=%0d idx=%0d fb=%h exp=%h", i, vecs[i].op, vecs[i].idx, fb_out, vecs[i].exp_fb);
            check_frame(vecs[i].exp_fb, 1'b0);
            prev_fb = vecs[i].exp_fb;
        end

        // frame_load beats a simultaneous command
        wait_fs(0);
        repeat (3) @(negedge clk);
        bus.frame_load = 1'b1; bus.frame_data = 16'hA5C3;
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'b00; bus.cmd_idx = 4'd0;
        #1;
        chk("load cmd_ready", 32'(bus.cmd_ready), 0);
        @(negedge clk);
        bus.frame_load = 1'b0; bus.cmd_valid = 1'b0;
        wait_fs(0);
        chk("load fb", 32'(fb_out), 32'h0000A5C3);
        $display("load fb=%h", fb_out);
        check_frame(16'hA5C3, 1'b0);

        // back-to-back toggles then clear-all within one frame
        wait_fs(0);
        repeat (3) @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'b10; bus.cmd_idx = 4'd15;
        @(negedge clk);
        @(negedge clk);
        bus.cmd_op = 2'b11;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("multi fb before wrap", 32'(fb_out), 32'h0000A5C3);
        wait_fs(0);
        chk("clear-all fb", 32'(fb_out), 0);
        $display("clear-all fb=%h", fb_out);

        // command on the exact swap edge waits for the following frame
        repeat (3) @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'b00; bus.cmd_idx = 4'd1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (27) @(negedge clk);
        chk("race pre-edge row_out", 32'(row_out), 32'h8);
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'b00; bus.cmd_idx = 4'd3;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("race frame_start", 32'(frame_start), 1);
        chk("race fb this swap", 32'(fb_out), 32'h0002);
        wait_fs(0);
        chk("race fb next swap", 32'(fb_out), 32'h000A);
        $display("race fb=%h", fb_out);

        // all-on image for blink / enable tests
        repeat (3) @(negedge clk);
        bus.frame_load = 1'b1; bus.frame_data = 16'hFFFF;
        @(negedge clk);
        bus.frame_load = 1'b0;
        wait_fs(0);
        chk("full fb", 32'(fb_out), 32'h0000FFFF);
        repeat (21) @(negedge clk);
        chk("r2s5 row_out", 32'(row_out), 32'h4);
        chk("r2s5 col_out", 32'(col_out), 32'hF);
        en = 1'b0;
        @(negedge clk);
        chk("disable row_out", 32'(row_out), 0);
        chk("disable col_out", 32'(col_out), 0);
        chk("disable frame_start", 32'(frame_start), 0);
        @(negedge clk);
        chk("disabled row_out", 32'(row_out), 0);
        en = 1'b1; blink_en = 1'b1;
        @(negedge clk);
        chk("re-enable frame_start", 32'(frame_start), 1);
        for (int f = 0; f < 8; f++) begin
            if (f > 0) @(negedge clk);
            check_frame(16'hFFFF, (f == 2 || f == 3 || f == 6 || f == 7));
            $display("blink frame %0d checked", f);
        end

        // reset mid-frame discards buffers
        blink_en = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset fb", 32'(fb_out), 0);
        chk("midreset row_out", 32'(row_out), 0);
        chk("midreset cmd_ready", 32'(bus.cmd_ready), 0);
        rst_n = 1'b1;
        wait_fs(0);
        wait_fs(0);
        chk("post-reset fb", 32'(fb_out), 0);

        // 3x3: out-of-range index then highest valid index
        rst_b_n = 1'b1; en_b = 1'b1;
        wait_fs(1);
        repeat (3) @(negedge clk);
        bus_b.cmd_valid = 1'b1; bus_b.cmd_op = 2'b00; bus_b.cmd_idx = 4'd9;
        #1;
        chk("3x3 idx9 cmd_ready", 32'(bus_b.cmd_ready), 1);
        @(negedge clk);
        bus_b.cmd_valid = 1'b0;
        wait_fs(1);
        wait_fs(1);
        chk("3x3 idx9 fb", 32'(fb_b), 0);
        repeat (3) @(negedge clk);
        bus_b.cmd_valid = 1'b1; bus_b.cmd_idx = 4'd8;
        @(negedge clk);
        bus_b.cmd_valid = 1'b0;
        wait_fs(1);
        chk("3x3 idx8 fb", 32'(fb_b), 32'h100);
        $display("3x3 fb=%h", fb_b);
        for (int k = 0; k < 24; k++) begin
            if (k > 0) @(negedge clk);
            r = k / 8;
            s = k % 8;
            exp_row3 = (s < 2) ? 3'b0 : (3'b1 << r);
            exp_col3 = (s < 2 || r != 2) ? 3'b0 : 3'b100;
            chk($sformatf("3x3 row r%0d s%0d", r, s), 32'(row_b), 32'(exp_row3));
            chk($sformatf("3x3 col r%0d s%0d", r, s), 32'(col_b), 32'(exp_col3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
